// File: rtl/booth_divider_pkg.sv
// Shared arithmetic-unit definitions: divider state encoding and latency helper.
package booth_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Cycles from the accepting edge until valid is first observed high.
  function automatic int div_latency(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/booth_divider_if.sv
// Request/result bundle for the sequential signed divider.
interface booth_divider_if #(
  parameter int WIDTH = 4
);

  logic                        start;
  logic signed [2*WIDTH-1:0]   dividend;
  logic signed [WIDTH-1:0]     divisor;
  logic                        ready;
  logic                        valid;
  logic signed [2*WIDTH-1:0]   quotient;
  logic signed [WIDTH-1:0]     remainder;
  logic                        div_by_zero;
  logic                        overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/booth_divider_div_nr_step.sv
// One radix-2 non-restoring division iteration on magnitudes (purely combinational).
module div_nr_step #(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH+1:0]   r_in,
  input  logic        [2*WIDTH-1:0] q_in,
  input  logic        [WIDTH-1:0]   d_in,
  output logic signed [WIDTH+1:0]   r_out,
  output logic        [2*WIDTH-1:0] q_out
);

  logic signed [WIDTH+1:0] r_sh_s;
  logic signed [WIDTH+1:0] d_ext_s;

  // Shift {R,Q} left, add or subtract D by the old sign of R, append the new quotient bit.
  always_comb begin
    r_sh_s  = {r_in[WIDTH:0], q_in[2*WIDTH-1]};
    d_ext_s = {2'b00, d_in};
    if (r_in[WIDTH+1] == 1'b0) begin
      r_out = r_sh_s - d_ext_s;
    end else begin
      r_out = r_sh_s + d_ext_s;
    end
    q_out = {q_in[2*WIDTH-2:0], ~r_out[WIDTH+1]};
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, truncating quotient
// and remainder from non-restoring iteration on magnitudes plus a sign fix-up.
module booth_divider
  import booth_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           reset,
  booth_divider_if.slave bus
);

  localparam int QW = 2 * WIDTH;
  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(QW);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CALC  = CALC;
  localparam logic [1:0] S_FIXUP = FIXUP;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [QW-1:0]    Q_ZERO = {QW{1'b0}};
  localparam logic [QW-1:0]    Q_MIN  = {1'b1, {(QW-1){1'b0}}};
  localparam logic [RW-1:0]    R_ZERO = {RW{1'b0}};
  localparam logic [WIDTH-1:0] D_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] D_ONES = {WIDTH{1'b1}};

  logic [1:0]           state_r;
  logic [CW-1:0]        cnt_r;
  logic [QW-1:0]        q_r;
  logic [WIDTH-1:0]     d_r;
  logic signed [RW-1:0] r_r;
  logic                 neg_dvd_r;
  logic                 neg_dvs_r;
  logic                 dbz_r;
  logic                 ovf_r;
  logic [WIDTH-1:0]     dvd_lo_r;
  logic                 fix_phase_r;

  logic [QW-1:0]        quotient_r;
  logic [WIDTH-1:0]     remainder_r;
  logic                 valid_r;
  logic                 dbz_out_r;
  logic                 ovf_out_r;

  logic                 ready_s;
  logic                 accept_s;
  logic [QW-1:0]        dvd_abs_s;
  logic [WIDTH-1:0]     dvs_abs_s;
  logic [QW-1:0]        q_fix_s;
  logic [RW-1:0]        rem_full_s;
  logic signed [RW-1:0] r_step_s;
  logic [QW-1:0]        q_step_s;

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_r),
    .q_in  (q_r),
    .d_in  (d_r),
    .r_out (r_step_s),
    .q_out (q_step_s)
  );

  // Handshake decode, operand magnitudes and signed result reconstruction.
  always_comb begin
    ready_s  = (state_r == S_IDLE) || (state_r == S_DONE);
    accept_s = bus.start && ready_s;
    if (bus.dividend[QW-1]) begin
      dvd_abs_s = Q_ZERO - bus.dividend;
    end else begin
      dvd_abs_s = bus.dividend;
    end
    if (bus.divisor[WIDTH-1]) begin
      dvs_abs_s = D_ZERO - bus.divisor;
    end else begin
      dvs_abs_s = bus.divisor;
    end
    if (neg_dvd_r ^ neg_dvs_r) begin
      q_fix_s = Q_ZERO - q_r;
    end else begin
      q_fix_s = q_r;
    end
    if (neg_dvd_r) begin
      rem_full_s = R_ZERO - r_r;
    end else begin
      rem_full_s = r_r;
    end
  end

  // FSM and datapath; FIXUP restores R in its first cycle and publishes in its second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CW{1'b0}};
      q_r         <= Q_ZERO;
      d_r         <= D_ZERO;
      r_r         <= R_ZERO;
      neg_dvd_r   <= 1'b0;
      neg_dvs_r   <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      dvd_lo_r    <= D_ZERO;
      fix_phase_r <= 1'b0;
      quotient_r  <= Q_ZERO;
      remainder_r <= D_ZERO;
      valid_r     <= 1'b0;
      dbz_out_r   <= 1'b0;
      ovf_out_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            q_r         <= dvd_abs_s;
            d_r         <= dvs_abs_s;
            r_r         <= R_ZERO;
            neg_dvd_r   <= bus.dividend[QW-1];
            neg_dvs_r   <= bus.divisor[WIDTH-1];
            dbz_r       <= (bus.divisor == D_ZERO);
            ovf_r       <= (bus.dividend == Q_MIN) && (bus.divisor == D_ONES);
            dvd_lo_r    <= bus.dividend[WIDTH-1:0];
            cnt_r       <= CW'(QW - 1);
            fix_phase_r <= 1'b0;
            valid_r     <= 1'b0;
            state_r     <= S_CALC;
          end
        end
        S_CALC: begin
          r_r <= r_step_s;
          q_r <= q_step_s;
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= S_FIXUP;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        S_FIXUP: begin
          if (!fix_phase_r) begin
            if (r_r[RW-1]) begin
              r_r <= r_r + {2'b00, d_r};
            end
            fix_phase_r <= 1'b1;
          end else begin
            if (dbz_r) begin
              quotient_r  <= {QW{1'b1}};
              remainder_r <= dvd_lo_r;
            end else if (ovf_r) begin
              quotient_r  <= Q_MIN;
              remainder_r <= D_ZERO;
            end else begin
              quotient_r  <= q_fix_s;
              remainder_r <= rem_full_s[WIDTH-1:0];
            end
            dbz_out_r <= dbz_r;
            ovf_out_r <= ovf_r;
            valid_r   <= 1'b1;
            state_r   <= S_DONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = ready_s;
  assign bus.valid       = valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_out_r;
  assign bus.overflow    = ovf_out_r;

endmodule

// File: tb/tb_booth_divider.sv
// Directed and exhaustive self-checking bench for booth_divider at WIDTH=4.
module tb_booth_divider;
  import booth_divider_pkg::*;

  localparam int W   = 4;
  localparam int LAT = div_latency(W);

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  booth_divider_if #(.WIDTH(W)) bus ();

  booth_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // Waits for ready, issues one request, returns edges until valid (capped at 40).
  task automatic run_div(input logic [7:0] dvd, input logic [3:0] dvs, output int lat);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL ready_wait: got %b exp 1", bus.ready);
    end
    bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", bus.ready); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", bus.valid); end
    total++; if (bus.quotient !== 8'h00) begin bad++; $display("FAIL reset_quotient: got %h exp 00", bus.quotient); end
    total++; if (bus.remainder !== 4'h0) begin bad++; $display("FAIL reset_remainder: got %h exp 0", bus.remainder); end
    total++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got %b%b exp 00", bus.div_by_zero, bus.overflow);
    end
  endtask

  task automatic test_basic;
    int lat;
    run_div(8'd100, 4'd7, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d exp %0d", lat, LAT); end
    total++; if (bus.quotient !== 8'd14) begin bad++; $display("FAIL basic_quotient: got %h exp 0e", bus.quotient); end
    total++; if (bus.remainder !== 4'd2) begin bad++; $display("FAIL basic_remainder: got %h exp 2", bus.remainder); end
    total++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
      bad++; $display("FAIL basic_flags: got %b%b exp 00", bus.div_by_zero, bus.overflow);
    end
  endtask

  task automatic test_signs;
    logic [7:0] dvd [3];
    logic [3:0] dvs [3];
    logic [7:0] eq  [3];
    logic [3:0] er  [3];
    int lat;
    dvd = '{8'h9C, 8'h64, 8'h9C};   // -100, 100, -100
    dvs = '{4'h7, 4'h9, 4'h9};      //    7,  -7,   -7
    eq  = '{8'hF2, 8'hF2, 8'h0E};   //  -14, -14,   14
    er  = '{4'hE, 4'h2, 4'hE};      //   -2,   2,   -2
    for (int i = 0; i < 3; i++) begin
      run_div(dvd[i], dvs[i], lat);
      total++;
      if (bus.quotient !== eq[i] || bus.remainder !== er[i] || lat != LAT) begin
        bad++;
        $display("FAIL sign_case%0d: got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d",
                 i, bus.quotient, bus.remainder, lat, eq[i], er[i], LAT);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_div(8'h25, 4'h0, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL dbz_latency: got %0d exp %0d", lat, LAT); end
    total++; if (bus.quotient !== 8'hFF) begin bad++; $display("FAIL dbz_quotient: got %h exp ff", bus.quotient); end
    total++; if (bus.remainder !== 4'h5) begin bad++; $display("FAIL dbz_remainder: got %h exp 5", bus.remainder); end
    total++; if ({bus.div_by_zero, bus.overflow} !== 2'b10) begin
      bad++; $display("FAIL dbz_flags: got %b%b exp 10", bus.div_by_zero, bus.overflow);
    end
  endtask

  task automatic test_overflow;
    int lat;
    run_div(8'h80, 4'hF, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL ovf_latency: got %0d exp %0d", lat, LAT); end
    total++; if (bus.quotient !== 8'h80) begin bad++; $display("FAIL ovf_quotient: got %h exp 80", bus.quotient); end
    total++; if (bus.remainder !== 4'h0) begin bad++; $display("FAIL ovf_remainder: got %h exp 0", bus.remainder); end
    total++; if ({bus.div_by_zero, bus.overflow} !== 2'b01) begin
      bad++; $display("FAIL ovf_flags: got %b%b exp 01", bus.div_by_zero, bus.overflow);
    end
  endtask

  task automatic test_busy;
    int lat;
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0;
    while (bus.valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat != LAT) begin bad++; $display("FAIL busy_latency: got %0d exp %0d", lat, LAT); end
    total++; if (bus.quotient !== 8'd3 || bus.remainder !== 4'd0) begin
      bad++; $display("FAIL busy_result: got q=%h r=%h exp q=03 r=0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.start = 1'b1; bus.dividend = 8'hF9; bus.divisor = 4'd2;  // -7 / 2
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %b exp 0", bus.valid); end
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat != LAT) begin bad++; $display("FAIL b2b_latency: got %0d exp %0d", lat, LAT); end
    total++; if (bus.quotient !== 8'hFD || bus.remainder !== 4'hF) begin
      bad++; $display("FAIL b2b_result: got q=%h r=%h exp q=fd r=f", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b exp 1", bus.ready); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b exp 0", bus.valid); end
    total++; if (bus.quotient !== 8'h00 || bus.remainder !== 4'h0) begin
      bad++; $display("FAIL mid_reset_data: got q=%h r=%h exp q=00 r=0", bus.quotient, bus.remainder);
    end
    total++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
      bad++; $display("FAIL mid_reset_flags: got %b%b exp 00", bus.div_by_zero, bus.overflow);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_div(8'd9, 4'd3, lat);
    total++; if (lat != LAT || bus.quotient !== 8'd3 || bus.remainder !== 4'd0) begin
      bad++; $display("FAIL mid_reset_after: got q=%h r=%h lat=%0d exp q=03 r=0 lat=%0d",
                      bus.quotient, bus.remainder, lat, LAT);
    end
  endtask

  task automatic test_sweep;
    int  lat, qi, ri, ar, br;
    bit  ok;
    logic [3:0] alo;
    for (int a = -128; a < 128; a++) begin
      for (int b = -8; b < 8; b++) begin
        run_div(8'(a), 4'(b), lat);
        qi  = int'(bus.quotient);
        ri  = int'(bus.remainder);
        alo = 4'(a);
        ar  = (ri < 0) ? -ri : ri;
        br  = (b < 0) ? -b : b;
        if (b == 0) begin
          ok = bus.div_by_zero === 1'b1 && bus.overflow === 1'b0 &&
               bus.quotient === 8'hFF && bus.remainder === alo;
        end else if (a == -128 && b == -1) begin
          ok = bus.overflow === 1'b1 && bus.div_by_zero === 1'b0 &&
               bus.quotient === 8'h80 && bus.remainder === 4'h0;
        end else begin
          ok = bus.div_by_zero === 1'b0 && bus.overflow === 1'b0 &&
               (qi * b + ri == a) && (ar < br) && (ri == 0 || ((ri < 0) == (a < 0)));
        end
        total++;
        if (!ok || lat != LAT) begin
          bad++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%b ovf=%b lat=%0d exp invariants lat=%0d",
                   a, b, qi, ri, bus.div_by_zero, bus.overflow, lat, LAT);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.dividend = 8'h00; bus.divisor = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_signs;
    test_div_zero;
    test_overflow;
    test_busy;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
